// File: rtl/multisim_arb_pkg.sv
// Shared types and helpers for the multisim push arbiter.
package multisim_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int STAT_WIDTH = 32;

    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/multisim_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module multisim_rr_picker
    import multisim_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan offsets from farthest to nearest so the nearest request wins.
    always_comb begin : p_scan
        int j;
        j     = 0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j     = (int'(i_ptr) + k) % N;
            o_idx = i_req[j] ? IW'(j) : o_idx;
            o_any = o_any | i_req[j];
        end
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = o_any && (o_idx == IW'(i));
        end
    end

endmodule

// File: rtl/multisim_push_arbiter.sv
// Round-robin, message-locking arbiter feeding one multisim push channel.
// Optional statistics counters enabled by MULTISIM_PUSH_ARB_STATS_EN.
module multisim_push_arbiter
    import multisim_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 64,
    localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_vld,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [DATA_WIDTH-1:0]        req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] out_data,
    output logic                         out_last
`ifdef MULTISIM_PUSH_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]        stat_beats [NUM_REQ],
    output logic [STAT_WIDTH-1:0]        stat_stall
`endif
);

    arb_state_e                      r_state;
    arb_state_e                      w_state_nxt;
    logic [ID_WIDTH-1:0]             r_rr_ptr;
    logic [ID_WIDTH-1:0]             w_rr_ptr_nxt;
    logic [ID_WIDTH-1:0]             r_lock_id;
    logic [ID_WIDTH-1:0]             w_lock_id_nxt;
    logic                            r_out_vld;
    logic [ID_WIDTH+DATA_WIDTH-1:0]  r_out_data;
    logic                            r_out_last;

    logic [NUM_REQ-1:0]              w_lock_mask;
    logic [NUM_REQ-1:0]              w_pick_req;
    logic [NUM_REQ-1:0]              w_gnt;
    logic [ID_WIDTH-1:0]             w_idx;
    logic                            w_any;
    logic                            w_load_en;
    logic                            w_accept;

    function automatic logic [ID_WIDTH-1:0] rr_next(input logic [ID_WIDTH-1:0] x);
        return (x == ID_WIDTH'(NUM_REQ - 1)) ? '0 : x + ID_WIDTH'(1);
    endfunction

    // While locked, only the owner of the message is presented to the picker.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_lock_mask[i] = (r_lock_id == ID_WIDTH'(i));
        end
        if (r_state == LOCKED) begin
            w_pick_req = req_vld & w_lock_mask;
        end else begin
            w_pick_req = req_vld;
        end
    end

    multisim_rr_picker #(
        .N  (NUM_REQ),
        .IW (ID_WIDTH)
    ) u_picker (
        .i_req (w_pick_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Handshake outputs; rst_n gating keeps req_rdy low throughout reset.
    always_comb begin
        w_load_en = !r_out_vld || out_rdy;
        w_accept  = rst_n && w_load_en && w_any;
        if (w_accept) begin
            req_rdy = w_gnt;
        end else begin
            req_rdy = '0;
        end
    end

    // Next-state, pointer and lock owner.
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_lock_id_nxt = r_lock_id;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_last[w_idx]) begin
                        w_rr_ptr_nxt = rr_next(w_idx);
                    end else begin
                        w_lock_id_nxt = w_idx;
                        w_state_nxt   = LOCKED;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOCKED: begin
                if (w_accept && req_last[w_idx]) begin
                    w_rr_ptr_nxt = rr_next(r_lock_id);
                    w_state_nxt  = IDLE;
                end else begin
                    w_state_nxt = LOCKED;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer and lock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    // Output beat register; a drain and a load on the same edge leave no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else if (w_load_en) begin
            r_out_vld <= w_accept;
            if (w_accept) begin
                r_out_data <= {w_idx, req_data[w_idx]};
                r_out_last <= req_last[w_idx];
            end
        end
    end

    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign out_last = r_out_last;

`ifdef MULTISIM_PUSH_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat_beats [NUM_REQ];
    logic [STAT_WIDTH-1:0] r_stat_stall;

    // Saturating per-requester beat counters and output stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat_beats[i] <= '0;
            end
            r_stat_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_rdy[i]) begin
                    r_stat_beats[i] <= sat_inc(r_stat_beats[i]);
                end
            end
            if (r_out_vld && !out_rdy) begin
                r_stat_stall <= sat_inc(r_stat_stall);
            end
        end
    end

    assign stat_beats = r_stat_beats;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_multisim_push_arbiter.sv
// Randomized bench for multisim_push_arbiter with a transaction-level reference model.
module tb_multisim_push_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_vld;
    logic [N-1:0]      req_last;
    logic [DW-1:0]     req_data [N];
    logic [N-1:0]      req_rdy;
    logic              out_vld;
    logic              out_rdy;
    logic [IW+DW-1:0]  out_data;
    logic              out_last;
`ifdef MULTISIM_PUSH_ARB_STATS_EN
    logic [31:0]       stat_beats [N];
    logic [31:0]       stat_stall;
`endif

    multisim_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_last (req_last),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_last (out_last)
`ifdef MULTISIM_PUSH_ARB_STATS_EN
        ,
        .stat_beats (stat_beats),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pointer, lock owner (-1 = none), expected output beat.
    int             m_ptr;
    int             m_lock;
    bit             m_vld;
    logic [IW+DW-1:0] m_data;
    bit             m_last;
    int             m_beats [N];
    int             m_stall;
    int             last_acc;
    int             left [N];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_lock = -1; m_vld = 0; m_data = '0; m_last = 0; m_stall = 0;
        for (int i = 0; i < N; i++) m_beats[i] = 0;
    endtask

    function automatic int exp_winner();
        if (m_lock >= 0) return req_vld[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            if (req_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        int w;
        bit load;
        logic [N-1:0] exp_rdy;
        #1;
        w = exp_winner();
        load = !m_vld || out_rdy;
        exp_rdy = '0;
        if (load && w >= 0) exp_rdy[w] = 1'b1;
        check_eq("req_rdy", 128'(req_rdy), 128'(exp_rdy));
        if (m_vld && !out_rdy) m_stall++;
        last_acc = -1;
        if (load) begin
            if (w >= 0) begin
                m_vld  = 1;
                m_data = {IW'(w), req_data[w]};
                m_last = req_last[w];
                m_beats[w]++;
                last_acc = w;
                if (req_last[w]) begin
                    m_ptr  = (w + 1) % N;
                    m_lock = -1;
                end else begin
                    m_lock = w;
                end
            end else begin
                m_vld = 0;
            end
        end
        @(posedge clk);
        #1;
        check_eq("out_vld", 128'(out_vld), 128'(m_vld));
        if (m_vld) begin
            check_eq("out_data", 128'(out_data), 128'(m_data));
            check_eq("out_last", 128'(out_last), 128'(m_last));
        end
        @(negedge clk);
    endtask

    initial begin
        int exp_ids [5];
        exp_ids = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; out_rdy = 1'b1; req_vld = '1; req_last = '0;
        for (int i = 0; i < N; i++) req_data[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_vld", 128'(out_vld), 128'(0));
        check_eq("rst_out_data", 128'(out_data), 128'(0));
        check_eq("rst_out_last", 128'(out_last), 128'(0));
        check_eq("rst_req_rdy", 128'(req_rdy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters valid with single-beat messages: strict rotation.
        req_last = '1;
        for (int i = 0; i < N; i++) req_data[i] = DW'(64'h1000 + i);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("rr_id", 128'(out_data[IW+DW-1:DW]), 128'(exp_ids[c]));
        end

        // Requester 2 three-beat message while 0 and 1 compete.
        @(negedge clk);
        model_reset();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req_vld = 4'b0100; req_last = '0; tick();
        req_vld = 4'b0111; tick();
        check_eq("lock_id2", 128'(out_data[IW+DW-1:DW]), 128'(2));
        req_last = 4'b0100; tick();
        check_eq("lock_last", 128'(out_last), 128'(1));
        req_last = '1; req_vld = 4'b1011; tick();
        check_eq("resume_3", 128'(out_data[IW+DW-1:DW]), 128'(3));

        // Stall with 0xDEAD held, then no-bubble reload.
        req_vld = 4'b0001; req_data[0] = DW'(64'hDEAD); tick();
        out_rdy = 1'b0; req_vld = '1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("stall_data", 128'(out_data[DW-1:0]), 128'(64'hDEAD));
        end
        out_rdy = 1'b1; tick();

        // Locked on 1, owner goes quiet while others request.
        req_vld = 4'b0010; req_last = '0; tick();
        req_vld = 4'b1001;
        for (int c = 0; c < 4; c++) tick();
        check_eq("lock_drain", 128'(out_vld), 128'(0));
        req_vld = 4'b1011; req_last = 4'b0010; tick();
        check_eq("lock_resume", 128'(out_data[IW+DW-1:DW]), 128'(1));

        // Reset asserted mid-message on requester 2.
        req_vld = 4'b0100; req_last = '0; tick();
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_vld", 128'(out_vld), 128'(0));
        check_eq("async_rst_rdy", 128'(req_rdy), 128'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req_vld = '1; req_last = '1; tick();
        check_eq("post_rst_id", 128'(out_data[IW+DW-1:DW]), 128'(0));

        // Randomized traffic with multi-beat messages and random back-pressure.
        for (int i = 0; i < N; i++) begin
            left[i] = $urandom_range(1, 4);
            req_data[i] = {$urandom, $urandom};
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                req_vld[i]  = ($urandom_range(0, 3) != 0);
                req_last[i] = (left[i] == 1);
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc >= 0) begin
                left[last_acc]--;
                if (left[last_acc] == 0) left[last_acc] = $urandom_range(1, 4);
                req_data[last_acc] = {$urandom, $urandom};
            end
        end

`ifdef MULTISIM_PUSH_ARB_STATS_EN
        for (int i = 0; i < N; i++) check_eq("stat_beats", 128'(stat_beats[i]), 128'(m_beats[i]));
        check_eq("stat_stall", 128'(stat_stall), 128'(m_stall));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
